// File: rtl/infrared_pkg.sv
// infrared_pkg
// Shared definitions for the NEC infrared transmitter and receiver:
//   - NEC segment durations in microseconds
//   - FSM state encoding (common to infrared_send and infrared_rcv)
//   - helper that turns a segment length into a down-counter reload value
package infrared_pkg;

  localparam int unsigned LEAD_MARK_US  = 9000;
  localparam int unsigned LEAD_SPACE_US = 4500;
  localparam int unsigned REP_SPACE_US  = 2250;
  localparam int unsigned BIT_MARK_US   = 560;
  localparam int unsigned ONE_SPACE_US  = 1690;
  localparam int unsigned ZERO_SPACE_US = 560;
  localparam int unsigned STOP_MARK_US  = 560;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_REP_SPACE  = 3'd3,
    ST_BIT_MARK   = 3'd4,
    ST_BIT_SPACE  = 3'd5,
    ST_STOP_MARK  = 3'd6,
    ST_GAP        = 3'd7
  } ir_state_t;

  typedef logic [23:0] dur_t;

  // Reload value for a segment of 'us' microseconds. The counter is loaded
  // on segment entry and the segment ends on the cycle it reads zero, so the
  // reload is the cycle count minus one.
  function automatic dur_t seg_cycles(input int unsigned us,
                                      input int unsigned clk_mhz,
                                      input int unsigned div);
    int unsigned cyc;
    cyc = us * clk_mhz / div;
    return dur_t'(cyc - 1);
  endfunction

  function automatic logic is_mark(input ir_state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/infrared_if.sv
// infrared_if
// Request/status bundle of the NEC transmitter.
//   start      : one-cycle send request (sampled only when idle)
//   repeat_req : qualifies start, 1 = send a repeat frame
//   addr, cmd  : NEC address / command, latched on an accepted start
//   ir_env     : envelope, 0 = mark, 1 = space/idle
//   ir_led     : LED drive, 1 = LED on
//   busy       : high from an accepted start until done
//   done       : one-cycle pulse when the frame period has elapsed
// master = requester side, slave = transmitter side.
interface infrared_if;
  logic       start;
  logic       repeat_req;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       ir_env;
  logic       ir_led;
  logic       busy;
  logic       done;

  modport master (
    output start, repeat_req, addr, cmd,
    input  ir_env, ir_led, busy, done
  );

  modport slave (
    input  start, repeat_req, addr, cmd,
    output ir_env, ir_led, busy, done
  );
endinterface

// File: rtl/infrared_carrier_gen.sv
// infrared_carrier_gen
// Raw IR carrier: toggles every HALF clock cycles while enabled.
//   sys_clk, sys_rst : clock, async active-high reset
//   restart          : sync restart, phase starts high on the next cycle
//   en               : run the carrier; when low the output is forced to 0
//   carrier          : registered carrier output
module infrared_carrier_gen #(
  parameter int unsigned HALF = 657
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  input  logic en,
  output logic carrier
);

  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= '0;
      carrier <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      carrier <= 1'b1;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt     <= '0;
        carrier <= ~carrier;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt     <= '0;
      carrier <= 1'b0;
    end
  end

endmodule

// File: rtl/infrared_send.sv
// infrared_send
// NEC infrared transmitter. Sends a full frame (lead mark, lead space,
// 32 data bits LSB first = addr, ~addr, cmd, ~cmd, stop mark) or a repeat
// frame, then waits out the frame period before reporting done.
//   sys_clk, sys_rst : clock, async active-high reset
//   bus (slave)      : start/repeat_req/addr/cmd in, ir_env/ir_led/busy/done out
// TIME_DIV divides every segment length and the frame period; 1 gives true
// NEC timing and larger values give a proportionally shortened frame.
//
// state      | meaning
// IDLE       | line idle, waiting for start
// LEAD_MARK  | 9 ms mark
// LEAD_SPACE | 4.5 ms space (full frame)
// REP_SPACE  | 2.25 ms space (repeat frame)
// BIT_MARK   | 560 us mark preceding each data bit
// BIT_SPACE  | 1690 us (one) or 560 us (zero) space, then shift
// STOP_MARK  | 560 us closing mark
// GAP        | idle line until the frame period expires
module infrared_send
  import infrared_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
  parameter int unsigned CARRIER_HZ      = 38_000,
  parameter bit          CARRIER_EN      = 1'b1,
  parameter int unsigned FRAME_PERIOD_US = 108_000,
  parameter int unsigned TIME_DIV        = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  infrared_if.slave   bus
);

  localparam int unsigned CLK_MHZ = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned HALF    = CLK_FREQ_HZ / (2 * CARRIER_HZ);

  localparam dur_t D_LEAD_MARK  = seg_cycles(LEAD_MARK_US,  CLK_MHZ, TIME_DIV);
  localparam dur_t D_LEAD_SPACE = seg_cycles(LEAD_SPACE_US, CLK_MHZ, TIME_DIV);
  localparam dur_t D_REP_SPACE  = seg_cycles(REP_SPACE_US,  CLK_MHZ, TIME_DIV);
  localparam dur_t D_BIT_MARK   = seg_cycles(BIT_MARK_US,   CLK_MHZ, TIME_DIV);
  localparam dur_t D_ONE_SPACE  = seg_cycles(ONE_SPACE_US,  CLK_MHZ, TIME_DIV);
  localparam dur_t D_ZERO_SPACE = seg_cycles(ZERO_SPACE_US, CLK_MHZ, TIME_DIV);
  localparam dur_t D_STOP_MARK  = seg_cycles(STOP_MARK_US,  CLK_MHZ, TIME_DIV);

  localparam logic [31:0] FRAME_LAST =
    32'(FRAME_PERIOD_US * CLK_MHZ / TIME_DIV - 1);

  ir_state_t   state, next_state;
  dur_t        dur_cnt, dur_load;
  logic        load_en;
  logic [31:0] frame_cnt;
  logic [31:0] shreg;
  logic [4:0]  bit_idx;
  logic        rep_q;
  logic        busy_q, done_q, env_q;

  logic        seg_done;
  logic        accept;
  logic        mark_cur, mark_next;
  logic        car_restart;
  logic        done_next;
  logic        busy_next;
  logic        carrier;

  assign seg_done = (dur_cnt == '0);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state logic, plus the duration to load on entering the new segment
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    dur_load   = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          next_state = ST_LEAD_MARK;
          load_en    = 1'b1;
          dur_load   = D_LEAD_MARK;
        end
      end
      ST_LEAD_MARK: begin
        if (seg_done) begin
          load_en = 1'b1;
          if (rep_q) begin
            next_state = ST_REP_SPACE;
            dur_load   = D_REP_SPACE;
          end else begin
            next_state = ST_LEAD_SPACE;
            dur_load   = D_LEAD_SPACE;
          end
        end
      end
      ST_LEAD_SPACE: begin
        if (seg_done) begin
          next_state = ST_BIT_MARK;
          load_en    = 1'b1;
          dur_load   = D_BIT_MARK;
        end
      end
      ST_BIT_MARK: begin
        if (seg_done) begin
          next_state = ST_BIT_SPACE;
          load_en    = 1'b1;
          dur_load   = shreg[0] ? D_ONE_SPACE : D_ZERO_SPACE;
        end
      end
      ST_BIT_SPACE: begin
        if (seg_done) begin
          load_en = 1'b1;
          if (bit_idx == 5'd31) begin
            next_state = ST_STOP_MARK;
            dur_load   = D_STOP_MARK;
          end else begin
            next_state = ST_BIT_MARK;
            dur_load   = D_BIT_MARK;
          end
        end
      end
      ST_REP_SPACE: begin
        if (seg_done) begin
          next_state = ST_STOP_MARK;
          load_en    = 1'b1;
          dur_load   = D_STOP_MARK;
        end
      end
      ST_STOP_MARK: begin
        if (seg_done) next_state = ST_GAP;
      end
      ST_GAP: begin
        if (frame_cnt == '0) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: values presented to the output registers
  always_comb begin
    accept      = (state == ST_IDLE) && bus.start;
    mark_cur    = is_mark(state);
    mark_next   = is_mark(next_state);
    // Marks are never back to back, so every mark entry restarts the carrier
    car_restart = mark_next && !mark_cur;
    done_next   = (state == ST_GAP) && (frame_cnt == '0);
    busy_next   = busy_q;
    if (accept)         busy_next = 1'b1;
    else if (done_next) busy_next = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dur_cnt   <= '0;
      frame_cnt <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      rep_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      env_q     <= 1'b1;
    end else begin
      if (load_en)        dur_cnt <= dur_load;
      else if (!seg_done) dur_cnt <= dur_cnt - 24'd1;

      // Frame period is measured from the acceptance cycle and holds at zero
      if (accept)                 frame_cnt <= FRAME_LAST;
      else if (frame_cnt != '0)   frame_cnt <= frame_cnt - 32'd1;

      if (accept) begin
        shreg   <= {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
        bit_idx <= '0;
        rep_q   <= bus.repeat_req;
      end else if ((state == ST_BIT_SPACE) && seg_done) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 5'd1;
      end

      busy_q <= busy_next;
      done_q <= done_next;
      env_q  <= !mark_next;
    end
  end

  infrared_carrier_gen #(
    .HALF (HALF)
  ) u_carrier (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (car_restart),
    .en      (mark_next),
    .carrier (carrier)
  );

  assign bus.ir_env = env_q;
  assign bus.ir_led = CARRIER_EN ? carrier : ~env_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_infrared_send.sv
// Bench for infrared_send at 1 MHz with every duration divided by 10:
// lead 900, lead space 450, repeat space 225, bit mark 56, one space 169,
// zero space 56, stop 56, frame period 10800, carrier half period 13 cycles.
module tb_infrared_send;

  localparam int LEAD   = 900;
  localparam int LSPACE = 450;
  localparam int RSPACE = 225;
  localparam int BMARK  = 56;
  localparam int ONE    = 169;
  localparam int ZERO   = 56;
  localparam int STOP   = 56;
  localparam int FRAME  = 10800;
  localparam int FULL   = 6798;
  localparam int HALF   = 13;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   car_bad = 0;
  bit   led_bad = 0;

  infrared_if bus ();

  infrared_send #(
    .CLK_FREQ_HZ     (1_000_000),
    .CARRIER_HZ      (38_000),
    .CARRIER_EN      (1'b1),
    .FRAME_PERIOD_US (108_000),
    .TIME_DIV        (10)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_start(input bit rep, input logic [7:0] a, input logic [7:0] c);
    @(posedge sys_clk); #1;
    bus.start = 1'b1; bus.repeat_req = rep; bus.addr = a; bus.cmd = c;
    @(posedge sys_clk); #1;
    bus.start = 1'b0; bus.repeat_req = 1'b0;
    acc_cyc = cyc;
  endtask

  // Length of the current ir_env run at level lvl, checking the carrier
  // pattern in marks and a dark LED in spaces.
  task automatic run_len(input logic lvl, input int limit, output int n);
    n = 0;
    while (bus.ir_env === lvl && n < limit) begin
      if (lvl == 1'b0) begin
        if (bus.ir_led !== (((n / HALF) % 2) == 0)) car_bad = 1;
      end else if (bus.ir_led !== 1'b0) led_bad = 1;
      @(posedge sys_clk); #1;
      n++;
    end
  endtask

  task automatic wait_done(input string tag);
    int  n;
    logic prev_busy;
    n = 0;
    prev_busy = bus.busy;
    while (bus.done !== 1'b1 && n < 2 * FRAME) begin
      if (bus.ir_env !== 1'b1 || bus.ir_led !== 1'b0) led_bad = 1;
      prev_busy = bus.busy;
      @(posedge sys_clk); #1;
      n++;
    end
    check({tag, "_done_time"}, 32'(cyc - acc_cyc), FRAME);
    check({tag, "_busy_fall"}, 32'(bus.busy), 0);
    check({tag, "_busy_before"}, 32'(prev_busy), 1);
    @(posedge sys_clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] a, input logic [7:0] c,
                            input logic [31:0] exp_data, input int exp_bit0);
    int n;
    logic [31:0] data;
    bit mark_bad;
    bit space_bad;
    car_bad = 0; led_bad = 0; mark_bad = 0; space_bad = 0; data = '0;
    send_start(1'b0, a, c);
    check({tag, "_busy_start"}, 32'(bus.busy), 1);
    check({tag, "_env_start"}, 32'(bus.ir_env), 0);
    run_len(1'b0, 2 * LEAD, n);
    check({tag, "_lead_mark"}, n, LEAD);
    run_len(1'b1, 2 * LSPACE, n);
    check({tag, "_lead_space"}, n, LSPACE);
    for (int i = 0; i < 32; i++) begin
      run_len(1'b0, 4 * BMARK, n);
      if (n != BMARK) mark_bad = 1;
      run_len(1'b1, 2 * ONE, n);
      if (i == 0) check({tag, "_bit0_space"}, n, exp_bit0);
      if (n == ONE) data[i] = 1'b1;
      else if (n != ZERO) space_bad = 1;
    end
    check({tag, "_bit_marks"}, 32'(mark_bad), 0);
    check({tag, "_bit_spaces"}, 32'(space_bad), 0);
    check({tag, "_data"}, data, exp_data);
    run_len(1'b0, 4 * STOP, n);
    check({tag, "_stop_mark"}, n, STOP);
    check({tag, "_frame_len"}, 32'(cyc - acc_cyc), FULL);
    wait_done(tag);
    check({tag, "_carrier"}, 32'(car_bad), 0);
    check({tag, "_led_dark"}, 32'(led_bad), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.repeat_req = 1'b0; bus.addr = 8'h00; bus.cmd = 8'h00;
    sys_rst = 1'b1;
    #100;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("rst_env", 32'(bus.ir_env), 1);
    check("rst_led", 32'(bus.ir_led), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);

    // repeat_req alone must not start anything
    bus.repeat_req = 1'b1;
    repeat (3) @(posedge sys_clk); #1;
    bus.repeat_req = 1'b0;
    check("rep_alone_busy", 32'(bus.busy), 0);
    check("rep_alone_env", 32'(bus.ir_env), 1);

    // Full frame 4D/80 -> {7F,80,B2,4D}; a start mid-frame must be ignored
    fork
      begin
        repeat (1500) @(posedge sys_clk);
        #2;
        bus.start = 1'b1; bus.addr = 8'hFF; bus.cmd = 8'h00;
        @(posedge sys_clk); #2;
        bus.start = 1'b0;
      end
    join_none
    full_frame("f1", 8'h4D, 8'h80, 32'h7F80_B24D, ONE);

    // Repeat frame
    car_bad = 0; led_bad = 0;
    send_start(1'b1, 8'h12, 8'h34);
    check("rep_busy", 32'(bus.busy), 1);
    run_len(1'b0, 2 * LEAD, n);
    check("rep_lead_mark", n, LEAD);
    run_len(1'b1, 2 * RSPACE, n);
    check("rep_space", n, RSPACE);
    run_len(1'b0, 4 * STOP, n);
    check("rep_stop_mark", n, STOP);
    check("rep_len", 32'(cyc - acc_cyc), LEAD + RSPACE + STOP);
    wait_done("rep");
    check("rep_carrier", 32'(car_bad), 0);
    check("rep_led_dark", 32'(led_bad), 0);

    // Reset during bit 0 space aborts at once
    send_start(1'b0, 8'h4D, 8'h80);
    repeat (LEAD + LSPACE + BMARK + 4) @(posedge sys_clk);
    #1;
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("abort_env", 32'(bus.ir_env), 1);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_led", 32'(bus.ir_led), 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (60) @(posedge sys_clk);
    #1;
    check("post_rst_env", 32'(bus.ir_env), 1);
    check("post_rst_done", 32'(bus.done), 0);

    // Next frame after the abort: addr 00, cmd FF -> {00,FF,FF,00}
    full_frame("f2", 8'h00, 8'hFF, 32'h00FF_FF00, ZERO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/infrared_send.md
Name: infrared_send

Overview:
NEC infrared transmitter. It is the transmit-side counterpart of infrared_rcv. It serialises an 8-bit address and 8-bit command into a full NEC frame: 9 ms lead mark, 4.5 ms space, 32 data bits sent LSB first (addr, ~addr, cmd, ~cmd), and a 560 us stop mark. It can also send an NEC repeat frame.
It drives two outputs:
- ir_env: a demodulated envelope, idle high, low during marks. It loops straight into infrared_in of infrared_rcv.
- ir_led: a carrier-modulated output for the IR LED driver.

Parameters:
- CLK_FREQ_HZ, 50_000_000: sys_clk frequency. CLK_MHZ = CLK_FREQ_HZ/1_000_000 must be an integer.
- CARRIER_HZ, 38_000: IR carrier frequency.
- CARRIER_EN, 1: 1 = ir_led carries the modulated carrier; 0 = ir_led equals ~ir_env.
- FRAME_PERIOD_US, 108_000: minimum interval from the start of one frame to acceptance of the next start.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle request, sampled only in IDLE.
- repeat_req, input, 1: qualifies start; 1 = send a repeat frame.
- addr, input, 8: NEC address, latched on an accepted start.
- cmd, input, 8: NEC command, latched on an accepted start.
- ir_env, output, 1: envelope; 0 = mark, 1 = space/idle.
- ir_led, output, 1: LED drive; 1 = LED on.
- busy, output, 1: high from an accepted start until done.
- done, output, 1: one-cycle pulse when the frame period has elapsed.

Behaviour:
- Reset values: ir_env=1, ir_led=0, busy=0, done=0, FSM=IDLE. All counters and the shift register are cleared.
- Reset asserted mid-frame aborts immediately and returns to the idle line levels. No partial stop mark is sent.
- Timing: a segment of T us lasts exactly T*CLK_MHZ sys_clk cycles. At 50 MHz, 560 us = 28_000 cycles.
  - Duration counter: 24 bits, loaded on entry to each segment, counts down to 0.
  - Frame counter: counts FRAME_PERIOD_US*CLK_MHZ cycles from the start-acceptance cycle.
- Start acceptance: start=1 in IDLE at edge k.
  - Latch shift register = {~cmd, cmd, ~addr, addr}, so bit 0 is sent first.
  - busy=1 and ir_env=0 from cycle k+1 (all outputs are registered).
  - start asserted while busy is ignored, with no queueing.
- FSM states:
  - IDLE -> LEAD_MARK (9000 us, ir_env=0).
  - LEAD_MARK -> REP_SPACE (2250 us) if repeat_req was latched, else LEAD_SPACE (4500 us).
  - LEAD_SPACE -> BIT_MARK (560 us).
  - BIT_MARK -> BIT_SPACE: 1690 us if the current bit is 1, 560 us if 0.
  - BIT_SPACE: shift right and increment the 5-bit bit index. After the 32nd bit (index wraps 31 -> 0) go to STOP_MARK, else to BIT_MARK.
  - REP_SPACE -> STOP_MARK (560 us).
  - STOP_MARK -> GAP (ir_env=1).
  - GAP: holds until the frame counter expires, then done=1 for one cycle, busy=0, and return to IDLE.
  - A new start is accepted no earlier than the cycle after done.
- Carrier:
  - HALF = CLK_FREQ_HZ/(2*CARRIER_HZ), integer floor; 657 at the defaults.
  - The carrier counter restarts on entry to every mark, so the carrier phase starts high.
  - ir_led toggles every HALF cycles during a mark and is 0 outside marks.
  - With CARRIER_EN=0, ir_led = ~ir_env.
- Frame length is data-independent, because every valid NEC payload contains exactly 16 ones:
  - Data field = 53_920 us.
  - Full frame, lead-mark start to end of stop mark = 67_980 us.
  - Repeat frame = 11_810 us.
- start and repeat_req are asserted together for a repeat. repeat_req without start is ignored. For a repeat, addr and cmd are latched but unused.

Decomposition:
- Package infrared_pkg holds:
  - NEC timing constants in us: LEAD_MARK_US=9000, LEAD_SPACE_US=4500, REP_SPACE_US=2250, BIT_MARK_US=560, ONE_SPACE_US=1690, ZERO_SPACE_US=560, STOP_MARK_US=560.
  - The FSM state encoding, shared with infrared_rcv.
- One sub-module, infrared_carrier_gen: a HALF-cycle toggler with a sync restart input and an enable input, producing the raw carrier.

Test Plan:
- Reset: hold sys_rst for 100 ns, then release -> ir_env=1, ir_led=0, busy=0, done=0.
- Full frame: start with addr=8'h4D, cmd=8'h80, looped into infrared_rcv.
  - ir_env low for 450_000 cycles, then high for 225_000.
  - Bit 0 space = 84_500 cycles (a 1).
  - Stop mark ends 3_399_000 cycles after the ir_env fall.
  - The receiver's data output decodes 4D/80.
- Timing: done is high 5_400_000 cycles after the start-acceptance cycle, and busy falls in the same cycle.
- Repeat frame: start with repeat_req=1 -> 450_000 low, 112_500 high, 28_000 low, then idle. The receiver asserts repeat_en.
- Busy and reset:
  - start pulsed mid-frame -> ignored; the frame is unchanged.
  - sys_rst pulsed during BIT_SPACE -> ir_env=1 and busy=0 immediately.
  - The next start after the reset produces a complete, correct frame.
- Carrier: CARRIER_EN=1 -> during the lead mark ir_led toggles every 657 cycles, starting high. Between marks ir_led=0.
